// File: rtl/demux_sequencer.sv
// Serialises a 4-bit word onto a 1-to-4 demux: one enabled channel per cycle, lowest index first.
// Optional SEQ_BACK2BACK_EN lets a new word be accepted during the DONE cycle.
module demux_sequencer (
   input  logic       iClk,
   input  logic       iRst,
   input  logic [3:0] iD,
   input  logic [3:0] iMask,
   input  logic       iValid,
   output logic       oReady,
   output logic       oC,
   output logic       oS1,
   output logic       oS0,
   output logic       oActive,
   output logic       oDone,
   output logic [1:0] oStateDbg
);

`ifdef SEQ_BACK2BACK_EN
   localparam logic Back2Back = 1'b1;
`else
   localparam logic Back2Back = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} stateT;

   stateT      state;
   logic [3:0] dataReg;
   logic [3:0] maskReg;
   logic [1:0] ptr;
   logic       readyReg;
   logic       accept;
   logic       lowAny;
   logic [1:0] lowIdx;
   logic       nextAny;
   logic [1:0] nextIdx;

   // Handshake: a word transfers on a rising edge where iValid and oReady are both 1;
   // oReady is forced low whenever iRst is high.
   assign oReady    = readyReg & ~iRst;
   assign accept    = iValid & readyReg;
   assign oStateDbg = state;

   always_comb begin
      lowAny  = |iMask;
      lowIdx  = 2'd0;
      nextAny = 1'b0;
      nextIdx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (iMask[i]) lowIdx = 2'(i);
         if (maskReg[i] && (i > int'(ptr))) begin
            nextAny = 1'b1;
            nextIdx = 2'(i);
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state    <= IDLE;
         dataReg  <= 4'd0;
         maskReg  <= 4'd0;
         ptr      <= 2'd0;
         oC       <= 1'b0;
         oS1      <= 1'b0;
         oS0      <= 1'b0;
         oActive  <= 1'b0;
         oDone    <= 1'b0;
         readyReg <= 1'b1;
      end else begin
         case (state)
            IDLE, DONE: begin
               // readyReg is only high in DONE when back-to-back is enabled
               if (accept) begin
                  dataReg <= iD;
                  maskReg <= iMask;
                  if (lowAny) begin
                     state      <= SEND;
                     ptr        <= lowIdx;
                     oActive    <= 1'b1;
                     oC         <= iD[lowIdx];
                     {oS1, oS0} <= lowIdx;
                     oDone      <= 1'b0;
                     readyReg   <= 1'b0;
                  end else begin
                     state      <= DONE;
                     ptr        <= 2'd0;
                     oActive    <= 1'b0;
                     oC         <= 1'b0;
                     {oS1, oS0} <= 2'b00;
                     oDone      <= 1'b1;
                     readyReg   <= Back2Back;
                  end
               end else begin
                  state      <= IDLE;
                  oActive    <= 1'b0;
                  oC         <= 1'b0;
                  {oS1, oS0} <= 2'b00;
                  oDone      <= 1'b0;
                  readyReg   <= 1'b1;
               end
            end
            SEND: begin
               if (nextAny) begin
                  ptr        <= nextIdx;
                  oC         <= dataReg[nextIdx];
                  {oS1, oS0} <= nextIdx;
               end else begin
                  state      <= DONE;
                  ptr        <= 2'd0;
                  oActive    <= 1'b0;
                  oC         <= 1'b0;
                  {oS1, oS0} <= 2'b00;
                  oDone      <= 1'b1;
                  readyReg   <= Back2Back;
               end
            end
            default: begin
               state      <= IDLE;
               oActive    <= 1'b0;
               oC         <= 1'b0;
               {oS1, oS0} <= 2'b00;
               oDone      <= 1'b0;
               readyReg   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_demux_sequencer.sv
// Scoreboard bench for demux_sequencer: driver pushes timed expected events, monitor pops on oActive/oDone.
module tb_demux_sequencer;

`ifdef SEQ_BACK2BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif
   localparam int W = 20;

   logic       iClk = 1'b0;
   logic       iRst;
   logic [3:0] iD;
   logic [3:0] iMask;
   logic       iValid;
   logic       oReady;
   logic       oC;
   logic       oS1;
   logic       oS0;
   logic       oActive;
   logic       oDone;
   logic [1:0] oStateDbg;

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         readyAt = 0;
   bit         started = 1'b0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] e;

   demux_sequencer dut (
      .iClk(iClk), .iRst(iRst), .iD(iD), .iMask(iMask), .iValid(iValid),
      .oReady(oReady), .oC(oC), .oS1(oS1), .oS0(oS0),
      .oActive(oActive), .oDone(oDone), .oStateDbg(oStateDbg)
   );

   // clock / reset block
   always #5 iClk = ~iClk;
   always @(posedge iClk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   // monitor: expected entry = {cycle[15:0], done, channel[1:0], data bit}
   always @(negedge iClk) begin
      if (started) begin
         if (oActive === 1'b1 || oDone === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output cyc=%0d got act=%b done=%b sel=%b%b c=%b exp=none",
                        cyc, oActive, oDone, oS1, oS0, oC);
            end else begin
               e = exp_q.pop_front();
               check("event", 32'({cyc[15:0], oDone, oS1, oS0, oC}), 32'(e));
            end
            if (oActive === 1'b1) check("ready_in_send", 32'(oReady), 32'd0);
         end else begin
            check("idle_outputs_zero", 32'({oC, oS1, oS0}), 32'd0);
         end
      end
   end

   // driver tasks
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge iClk); #1;
         iD    = 4'($urandom);
         iMask = 4'($urandom);
      end
   endtask

   task automatic sendWord(input logic [3:0] d, input logic [3:0] m);
      int startCyc, waited, p, acc, n;
      iD = d; iMask = m; iValid = 1'b1;
      startCyc = cyc;
      waited = 0;
      while (oReady !== 1'b1 && waited < 50) begin
         @(negedge iClk); #1;
         waited++;
      end
      if (oReady !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL ready_timeout cyc=%0d got oReady=%b exp=1", cyc, oReady);
         iValid = 1'b0;
         return;
      end
      check("accept_cycle", 32'(cyc), 32'((startCyc > readyAt) ? startCyc : readyAt));
      acc = cyc + 1;
      p = $countones(m);
      n = 0;
      for (int k = 0; k < 4; k++) begin
         if (m[k]) begin
            exp_q.push_back({16'(acc + n), 1'b0, 2'(k), d[k]});
            n++;
         end
      end
      exp_q.push_back({16'(acc + p), 1'b1, 2'b00, 1'b0});
      readyAt = acc + p + (B2B ? 0 : 1);
      @(negedge iClk); #1;
      iValid = 1'b0;
      iD     = 4'($urandom);
      iMask  = 4'($urandom);
   endtask

   initial begin
      int waited;
      // reset held two cycles with a word offered
      iRst = 1'b1; iValid = 1'b1; iD = 4'hF; iMask = 4'hF;
      repeat (2) @(posedge iClk);
      @(negedge iClk); #1;
      check("rst_ready", 32'(oReady), 32'd0);
      check("rst_outputs", 32'({oC, oS1, oS0, oActive, oDone}), 32'd0);
      iRst = 1'b0; iValid = 1'b0;
      readyAt = cyc + 1;
      started = 1'b1;
      @(negedge iClk); #1;
      check("post_rst_ready", 32'(oReady), 32'd1);
      check("post_rst_no_accept", 32'({oActive, oDone}), 32'd0);

      // full word, sparse mask, empty mask
      sendWord(4'b1010, 4'b1111);
      idle(3);
      sendWord(4'b1111, 4'b0101);
      idle(3);
      sendWord(4'b0110, 4'b0000);
      idle(3);

      // back-to-back with iValid held
      sendWord(4'b1100, 4'b1111);
      sendWord(4'b0011, 4'b1111);
      idle(4);

      // reset in the 2nd SEND cycle discards the word
      sendWord(4'b1111, 4'b1111);
      @(negedge iClk); #1;
      iRst = 1'b1;
      exp_q.delete();
      @(negedge iClk); #1;
      check("midrst_outputs", 32'({oC, oS1, oS0, oActive, oDone}), 32'd0);
      check("midrst_ready", 32'(oReady), 32'd0);
      iRst = 1'b0;
      readyAt = cyc + 1;
      idle(4);

      // randomized words and gaps
      for (int w = 0; w < 40; w++) begin
         sendWord(4'($urandom), 4'($urandom_range(0, 15)));
         idle($urandom_range(0, 3));
      end

      waited = 0;
      while (exp_q.size() > 0 && waited < 200) begin
         @(negedge iClk); #1;
         waited++;
      end
      idle(3);
      check("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
